io_ctrl_bank: RTL and testbench



---
 rtl/io_pkg.sv | 25 ++
 rtl/io_ctrl_bank_if.sv | 23 ++
 rtl/io_sync_edge.sv | 32 +++
 rtl/io_ctrl_bank.sv | 128 ++++++++++++
 tb/tb_io_ctrl_bank.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared register map constants and byte-enable merge helper for io_ctrl_bank.
package io_pkg;

   localparam int IO_OUT_BASE   = 'h00;
   localparam int IO_IN_BASE    = 'h20;
   localparam int IO_FLAGS_ADDR = 'h30;
   localparam int IO_MASK_ADDR  = 'h31;

   // Widest bus the merge helper handles; narrower words are zero-extended into it.
   localparam int IO_MAX_DW = 128;

   typedef logic [IO_MAX_DW-1:0]   io_word_t;
   typedef logic [IO_MAX_DW/8-1:0] io_be_t;

   function automatic io_word_t be_merge(input io_word_t old_v, input io_word_t new_v,
                                         input io_be_t be);
      io_word_t r;
      r = old_v;
      for (int b = 0; b < IO_MAX_DW/8; b++) begin
         if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/io_ctrl_bank_if.sv
// Processor data-memory port into the IO bank: strobed read/write, registered read return.
interface io_ctrl_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH-1:0]   io_addr;
   logic                    io_w_en;
   logic                    io_r_en;
   logic [DATA_WIDTH-1:0]   io_wdata;
   logic [DATA_WIDTH/8-1:0] io_be;
   logic [DATA_WIDTH-1:0]   io_rdata;
   logic                    io_rvalid;

   modport master (
      output io_addr, io_w_en, io_r_en, io_wdata, io_be,
      input  io_rdata, io_rvalid
   );

   modport slave (
      input  io_addr, io_w_en, io_r_en, io_wdata, io_be,
      output io_rdata, io_rvalid
   );
endinterface

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for one input channel plus rising-edge detect on the synced value.
// rise is combinational from q and the previous q; arm=1 enables detection.
module io_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             arm,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             rise
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= d;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q    = sync_q[SYNC_STAGES-1];
   assign rise = arm & (|(q & ~prev_q));

endmodule

// File: rtl/io_ctrl_bank.sv
// Memory-mapped IO bank: byte-enabled output registers, synchronised inputs with
// W1C rising-edge flags, interrupt mask and a registered level irq; one-cycle read latency.
module io_ctrl_bank
   import io_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_OUT     = 4,
   parameter int NUM_IN      = 4,
   parameter int IN_WIDTH    = 8,
   parameter int ADDR_WIDTH  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   io_ctrl_bank_if.slave                 bus,
   output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
   input  logic [NUM_IN*IN_WIDTH-1:0]    in_pins,
   output logic                          irq
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);

   if (NUM_IN > DATA_WIDTH || NUM_OUT > 16 || SYNC_STAGES < 2 ||
       IN_WIDTH > DATA_WIDTH || DATA_WIDTH > IO_MAX_DW) begin : g_param_check
      $error("io_ctrl_bank: illegal parameter combination");
   end

   logic [DATA_WIDTH-1:0] out_q [NUM_OUT];
   logic [DATA_WIDTH-1:0] out_d [NUM_OUT];
   logic [NUM_IN-1:0]     flags_q, flags_d, mask_q, mask_d, rise_vec, clr;
   logic [IN_WIDTH-1:0]   s_val [NUM_IN];
   logic [ARM_W-1:0]      arm_q, arm_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
   logic                  rvalid_q, rvalid_d, irq_q, irq_d;
   logic [NUM_OUT-1:0]    hit_out;
   logic                  hit_mask, hit_flags, armed;
   io_word_t              wr_old, merged;
   int                    addr;
   logic                  unused_merged;

   // Edge detection waits until the synchronisers have flushed post-reset state.
   assign armed = (arm_q == '0);

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      io_sync_edge #(
         .WIDTH       (IN_WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .arm   (armed),
         .d     (in_pins[g*IN_WIDTH +: IN_WIDTH]),
         .q     (s_val[g]),
         .rise  (rise_vec[g])
      );
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
   end

   always_comb begin
      addr    = int'(bus.io_addr);
      wr_old  = '0;
      hit_out = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         hit_out[i] = (addr == IO_OUT_BASE + i);
         if (hit_out[i]) wr_old = io_word_t'(out_q[i]);
      end
      hit_mask  = (addr == IO_MASK_ADDR);
      hit_flags = (addr == IO_FLAGS_ADDR);
      if (hit_mask) wr_old = io_word_t'(mask_q);
      merged = be_merge(wr_old, io_word_t'(bus.io_wdata), io_be_t'(bus.io_be));

      for (int i = 0; i < NUM_OUT; i++) begin
         out_d[i] = (bus.io_w_en && hit_out[i]) ? merged[DATA_WIDTH-1:0] : out_q[i];
      end
      mask_d = (bus.io_w_en && hit_mask) ? merged[NUM_IN-1:0] : mask_q;

      // A new edge in the same cycle as a W1C keeps the flag set.
      clr = '0;
      for (int j = 0; j < NUM_IN; j++) begin
         clr[j] = bus.io_w_en & hit_flags & bus.io_wdata[j] & bus.io_be[j/8];
      end
      flags_d = (flags_q & ~clr) | rise_vec;

      rd_word = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (hit_out[i]) rd_word = out_q[i];
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (addr == IO_IN_BASE + i) rd_word = DATA_WIDTH'(s_val[i]);
      end
      if (hit_flags) rd_word = DATA_WIDTH'(flags_q);
      if (hit_mask)  rd_word = DATA_WIDTH'(mask_q);

      rdata_d  = bus.io_r_en ? rd_word : rdata_q;
      rvalid_d = bus.io_r_en;
      irq_d    = |(flags_q & mask_q);
      arm_d    = (arm_q != '0) ? arm_q - 1'b1 : arm_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
         flags_q  <= '0;
         mask_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
         arm_q    <= ARM_W'(SYNC_STAGES + 1);
      end else begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
         flags_q  <= flags_d;
         mask_q   <= mask_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         irq_q    <= irq_d;
         arm_q    <= arm_d;
      end
   end

   assign bus.io_rdata  = rdata_q;
   assign bus.io_rvalid = rvalid_q;
   assign irq           = irq_q;
   assign unused_merged = ^merged;

endmodule

// File: tb/tb_io_ctrl_bank.sv
// Directed bench for io_ctrl_bank: register access, byte enables, input edge flags,
// arm suppression, W1C races, read/write collision and reset during a pending read.
module tb_io_ctrl_bank;

   localparam int DW = 32;
   localparam int NO = 4;
   localparam int NI = 4;
   localparam int IW = 8;
   localparam int AW = 6;
   localparam int SS = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NO*DW-1:0]  out_data;
   logic [NI*IW-1:0]  in_pins;
   logic              irq;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   io_ctrl_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   io_ctrl_bank #(
      .DATA_WIDTH (DW),
      .NUM_OUT    (NO),
      .NUM_IN     (NI),
      .IN_WIDTH   (IW),
      .ADDR_WIDTH (AW),
      .SYNC_STAGES(SS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .out_data (out_data),
      .in_pins  (in_pins),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
      bus.io_addr  = AW'(a);
      bus.io_wdata = d;
      bus.io_be    = be;
      bus.io_w_en  = 1'b1;
      tick();
      bus.io_w_en  = 1'b0;
   endtask

   // Read sampled at the next edge; data and valid are checked right after that edge.
   task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
      bus.io_addr = AW'(a);
      bus.io_r_en = 1'b1;
      tick();
      bus.io_r_en = 1'b0;
      chk({tag, "_rvalid"}, 128'(bus.io_rvalid), 128'(1));
      chk(tag, 128'(bus.io_rdata), 128'(exp));
   endtask

   initial begin
      rst_n        = 1'b0;
      in_pins      = '0;
      bus.io_addr  = '0;
      bus.io_w_en  = 1'b0;
      bus.io_r_en  = 1'b0;
      bus.io_wdata = '0;
      bus.io_be    = '0;
      tick();
      tick();
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_rvalid",   128'(bus.io_rvalid), 128'(0));
      chk("rst_rdata",    128'(bus.io_rdata), 128'(0));
      chk("rst_irq",      128'(irq), 128'(0));
      rst_n = 1'b1;
      tick();

      // 1: full-word write and one-cycle read latency
      wr('h01, 32'hDEADBEEF, 4'hF);
      chk("t1_ch1", 128'(out_data[63:32]), 128'(32'hDEADBEEF));
      rd_chk("t1_rd", 'h01, 32'hDEADBEEF);
      tick();
      chk("t1_rvalid_drop", 128'(bus.io_rvalid), 128'(0));
      chk("t1_rdata_hold",  128'(bus.io_rdata), 128'(32'hDEADBEEF));

      // 2: byte-enabled merge and unmapped read
      wr('h00, 32'hAABBCCDD, 4'hF);
      wr('h00, 32'h11223344, 4'h5);
      chk("t2_ch0", 128'(out_data[31:0]), 128'(32'hAA22CC44));
      rd_chk("t2_rd_3f", 'h3F, 32'h0);

      // 3: mask then rising edge on ch2, latency of s, flag and irq
      wr('h31, 32'h4, 4'hF);
      in_pins[23:16] = 8'h01;
      tick();                                   // edge k
      rd_chk("t3_s2_k1", 'h22, 32'h0);          // sampled at k+1
      rd_chk("t3_s2_k2", 'h22, 32'h1);          // sampled at k+2, flag sets here
      chk("t3_irq_k2", 128'(irq), 128'(0));
      rd_chk("t3_flags_k3", 'h30, 32'h4);       // sampled at k+3
      chk("t3_irq_k3", 128'(irq), 128'(1));

      // 5: W1C racing a new edge keeps the flag; plain W1C clears it
      in_pins[23:16] = 8'h00;
      for (int i = 0; i < 4; i++) tick();
      in_pins[23:16] = 8'h01;
      tick();                                   // edge k
      tick();                                   // edge k+1
      wr('h30, 32'h4, 4'hF);                    // edge k+2: set and clear together
      rd_chk("t5_flag_race", 'h30, 32'h4);
      chk("t5_irq_race", 128'(irq), 128'(1));
      wr('h30, 32'h4, 4'hF);                    // clear edge c
      chk("t5_irq_c", 128'(irq), 128'(1));
      tick();
      chk("t5_irq_c1", 128'(irq), 128'(0));
      rd_chk("t5_flag_clr", 'h30, 32'h0);

      // 6: same-cycle read/write returns pre-write data
      wr('h02, 32'h5, 4'hF);
      bus.io_addr  = AW'('h02);
      bus.io_wdata = 32'h9;
      bus.io_be    = 4'hF;
      bus.io_w_en  = 1'b1;
      bus.io_r_en  = 1'b1;
      tick();
      bus.io_w_en  = 1'b0;
      bus.io_r_en  = 1'b0;
      chk("t6_rw_rvalid", 128'(bus.io_rvalid), 128'(1));
      chk("t6_rw_rdata",  128'(bus.io_rdata), 128'(32'h5));
      chk("t6_ch2",       128'(out_data[95:64]), 128'(32'h9));
      rd_chk("t6_rd_new", 'h02, 32'h9);

      // 6/4: reset with a read pending, ch0 held high through reset
      in_pins      = '0;
      in_pins[7:0] = 8'hFF;
      bus.io_addr  = AW'('h01);
      bus.io_r_en  = 1'b1;
      rst_n        = 1'b0;
      tick();
      bus.io_r_en  = 1'b0;
      chk("t6_rst_rvalid", 128'(bus.io_rvalid), 128'(0));
      chk("t6_rst_rdata",  128'(bus.io_rdata), 128'(0));
      chk("t6_rst_out",    128'(out_data), 128'(0));
      chk("t6_rst_irq",    128'(irq), 128'(0));
      rst_n = 1'b1;
      wr('h31, 32'h1, 4'hF);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t4_irq_armed", 128'(irq), 128'(0));
      end
      rd_chk("t4_flags",   'h30, 32'h0);
      rd_chk("t4_in0",     'h20, 32'h000000FF);
      rd_chk("t4_in2",     'h22, 32'h0);
      rd_chk("t6_out1_rst",'h01, 32'h0);
      rd_chk("t4_mask",    'h31, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
